// File: rtl/packet_checker.sv
// packet_checker: AXI-Stream sink that checks the packet generator's output.
// Each packet has CYCLES_PER_PACKET beats, and every 32-bit lane of a beat
// carries the packet sequence word. The checker accepts every packet. It
// counts packets, beats and errored packets, and records which error classes
// have been seen.
module packet_checker #(
  parameter int unsigned STALL_PERIOD = 0,
  parameter int unsigned STALL_CYCLES = 0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [511:0] AXIS_IN_TDATA,
  input  logic [63:0]  AXIS_IN_TKEEP,
  input  logic         AXIS_IN_TLAST,
  input  logic         AXIS_IN_TVALID,
  output logic         AXIS_IN_TREADY,
  input  logic [15:0]  CYCLES_PER_PACKET,
  input  logic         clear,
  output logic [63:0]  packet_count,
  output logic [63:0]  beat_count,
  output logic [31:0]  error_count,
  output logic [3:0]   error_flags,
  output logic [31:0]  first_bad_seq,
  output logic [63:0]  active_cycles,
  output logic         busy
);

  typedef enum logic {IDLE, IN_PKT} state_t;

  localparam logic [31:0] STALL_LAST = (STALL_PERIOD == 0) ? 32'd0 : 32'(STALL_PERIOD - 1);
  localparam logic [31:0] STALL_LOW  = 32'(STALL_CYCLES);

  state_t      state;
  logic [31:0] stall_cnt;
  logic [31:0] expected_seq;
  logic [31:0] beat_idx;
  logic        pkt_err;
  logic        pkt_clean;
  logic [31:0] first_w;
  logic [63:0] timer;
  logic        timer_run;

  logic [31:0] w;
  logic [31:0] cpp32;
  logic [31:0] idx_now;
  logic        accept;
  logic        pat_err;
  logic        keep_err;
  logic        seq_err;
  logic        len_err;
  logic [3:0]  beat_errs;
  logic        pkt_err_now;
  logic [31:0] first_w_now;
  logic        clean_now;

  // Free-running backpressure phase counter; clear does not touch it.
  always_ff @(posedge clk) begin
    if (reset)
      stall_cnt <= '0;
    else if (STALL_PERIOD != 0)
      stall_cnt <= (stall_cnt == STALL_LAST) ? '0 : stall_cnt + 32'd1;
  end

  assign AXIS_IN_TREADY = !reset && ((STALL_PERIOD == 0) || (stall_cnt >= STALL_LOW));
  assign accept         = AXIS_IN_TVALID && AXIS_IN_TREADY;
  assign busy           = (state == IN_PKT);

  assign w       = AXIS_IN_TDATA[31:0];
  assign cpp32   = {16'd0, CYCLES_PER_PACKET};
  assign idx_now = (state == IN_PKT) ? ((beat_idx == '1) ? '1 : beat_idx + 32'd1) : 32'd1;

  // Per-beat error classification of the beat currently on the bus.
  always_comb begin
    pat_err = 1'b0;
    for (int unsigned i = 1; i < 16; i++) begin
      if (AXIS_IN_TDATA[i*32 +: 32] != w) pat_err = 1'b1;
    end
    keep_err    = (AXIS_IN_TKEEP != '1);
    seq_err     = (w != expected_seq);
    len_err     = (CYCLES_PER_PACKET == 16'd0) || (idx_now > cpp32) ||
                  (AXIS_IN_TLAST && (idx_now != cpp32));
    beat_errs   = {keep_err, len_err, seq_err, pat_err};
    // These merge the beat on the bus with what the current packet has latched
    // so far; they select the live beat when it opens a packet.
    pkt_err_now = ((state == IN_PKT) && pkt_err) || (beat_errs != 4'd0);
    first_w_now = (state == IN_PKT) ? first_w : w;
    clean_now   = (state == IN_PKT) ? pkt_clean : (error_flags == 4'd0);
  end

  // Packet state machine, per-packet error latch, counters and timing.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      state         <= IDLE;
      expected_seq  <= 32'd1;
      beat_idx      <= '0;
      pkt_err       <= 1'b0;
      pkt_clean     <= 1'b0;
      first_w       <= '0;
      timer         <= '0;
      timer_run     <= 1'b0;
      packet_count  <= '0;
      beat_count    <= '0;
      error_count   <= '0;
      error_flags   <= '0;
      first_bad_seq <= '0;
      active_cycles <= '0;
    end else begin
      if (timer_run) timer <= timer + 64'd1;
      if (accept) begin
        beat_count  <= beat_count + 64'd1;
        error_flags <= error_flags | beat_errs;
        if (!timer_run) begin
          timer_run <= 1'b1;
          timer     <= 64'd1;
        end
        if (AXIS_IN_TLAST) begin
          state         <= IDLE;
          beat_idx      <= '0;
          pkt_err       <= 1'b0;
          packet_count  <= packet_count + 64'd1;
          expected_seq  <= w + 32'd1;
          active_cycles <= timer_run ? timer + 64'd1 : 64'd1;
          if (pkt_err_now) begin
            if (error_count != '1) error_count <= error_count + 32'd1;
            if (clean_now) first_bad_seq <= first_w_now;
          end
        end else begin
          state     <= IN_PKT;
          beat_idx  <= idx_now;
          pkt_err   <= pkt_err_now;
          first_w   <= first_w_now;
          pkt_clean <= clean_now;
        end
      end
    end
  end

endmodule
